truth_table_sweeper: RTL and testbench

- Self-checking stimulus/response engine for 4-input combinational lab circuits.
- Is the driving and checking end of a DUT's input/output interface.
- Sweeps every input combination onto `stim`, waits a settle interval, samples the DUT's single-bit response and compares it against a golden truth table.
- Reports mismatch count, first failing index and pass/fail, so lab circuits are verified in hardware without a simulator console.

---
 rtl/truth_table_sweeper.sv | 67 ++++++
 tb/tb_truth_table_sweeper.sv | 107 ++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps every input vector on stim, waits SETTLE cycles per vector, checks dut_out against GOLDEN, reports err_count/first_fail_idx/pass
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int SETTLE = 2,
  parameter logic [2**N_IN-1:0] GOLDEN = 16'h70FF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_SAMPLE = 2'd2, S_DONE = 2'd3;
  logic [1:0] state;
  logic [7:0] cnt;
  logic bad, last, go;
  assign bad = dut_out != GOLDEN[stim];
  assign last = &stim;
  assign go = start && (state == S_IDLE || state == S_DONE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
      cnt <= '0;
    end else if (go) begin
      state <= S_SETTLE;
      stim <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
      cnt <= 8'(SETTLE - 1);
    end else if (state == S_SETTLE) begin
      if (cnt == 8'd0) state <= S_SAMPLE;
      else cnt <= cnt - 8'd1;
    end else if (state == S_SAMPLE) begin
      if (bad) err_count <= err_count + 1'b1;
      if (bad && !first_fail_valid) begin
        first_fail_idx <= stim;
        first_fail_valid <= 1'b1;
      end
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == '0) && !bad;
        state <= S_DONE;
      end else begin
        stim <= stim + 1'b1;
        cnt <= 8'(SETTLE - 1);
        state <= S_SETTLE;
      end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench driving lab-circuit models through the sweeper
module tb_truth_table_sweeper;
  logic clk = 1'b0, rst, start, dut_out;
  logic [3:0] stim, first_fail_idx;
  logic busy, done, pass, first_fail_valid;
  logic [4:0] err_count;
  int mode;
  int tests = 0, fails = 0;
  typedef struct {logic pass; logic [4:0] err; logic [3:0] ffi; logic ffv;} res_t;
  res_t q[$];
  always #5 clk = ~clk;
  truth_table_sweeper dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out), .stim(stim), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid)
  );
  logic ref_out;
  assign ref_out = ~(((stim[0] & stim[1]) | ~stim[2]) & stim[3]);
  assign dut_out = mode == 1 ? 1'b0 : mode == 2 ? ref_out ^ (stim == 4'd12) : ref_out;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 0, 1);
  endtask
  int lat = 0, stim_err = 0;
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (busy) begin
      if (stim != 4'(lat / 3)) stim_err++;
      lat++;
    end else if (done && !done_q) begin
      chk("latency", lat, 48);
      chk("stim_sequence_errors", stim_err, 0);
      chk("final_stim", stim, 15);
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        res_t e;
        e = q.pop_front();
        chk("result{pass,err,ffi,ffv}", {pass, err_count, first_fail_idx, first_fail_valid},
            {e.pass, e.err, e.ffi, e.ffv});
      end
      lat = 0;
      stim_err = 0;
    end else begin
      lat = 0;
      stim_err = 0;
    end
    done_q = done;
  end
  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid}, 0);
    q.push_back('{1'b1, 5'd0, 4'd0, 1'b0});
    pulse_start;
    chk("busy_after_start", busy, 1);
    repeat (9) @(negedge clk);
    pulse_start;
    wait_done;
    mode = 1;
    q.push_back('{1'b0, 5'd11, 4'd0, 1'b1});
    pulse_start;
    wait_done;
    mode = 0;
    q.push_back('{1'b1, 5'd0, 4'd0, 1'b0});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_done_drop", {done, pass, busy}, 3'b001);
    wait_done;
    mode = 2;
    q.push_back('{1'b0, 5'd1, 4'd12, 1'b1});
    pulse_start;
    wait_done;
    mode = 0;
    pulse_start;
    for (int i = 0; i < 100 && stim != 4'd7; i++) @(negedge clk);
    chk("reach_stim7", stim, 7);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    mode = 1;
    q.push_back('{1'b0, 5'd11, 4'd0, 1'b1});
    pulse_start;
    wait_done;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
